al_memwr_sched: RTL and testbench

Multi-channel scheduler that feeds the MemWr transfer-queue (`tcq`) port of the RAM-to-PCIe write engine. It splits per-channel DMA descriptors into bursts that obey Max Payload Size, the 4 KB boundary rule and the engine's maximum request length. Channels are served round-robin at burst granularity. The block counts per-channel outstanding bursts through the engine's completion (`cvalid`/`ctag`) stream and signals descriptor completion once every burst of a descriptor has been confirmed.

---
 rtl/al_dma_pkg.sv | 25 ++
 rtl/al_memwr_sched_if.sv | 29 ++
 rtl/al_memwr_chunk_calc.sv | 37 +++
 rtl/al_memwr_sched.sv | 206 ++++++++++++++++++++
 tb/tb_al_memwr_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/al_dma_pkg.sv
// Shared DMA definitions: PCIe MPS encodings, 4 KB boundary width and the
// MPS-to-beats helper used by the write schedulers.
package al_dma_pkg;

  localparam logic [2:0] MPS_128  = 3'd0;
  localparam logic [2:0] MPS_256  = 3'd1;
  localparam logic [2:0] MPS_512  = 3'd2;
  localparam logic [2:0] MPS_1024 = 3'd3;
  localparam logic [2:0] MPS_2048 = 3'd4;
  localparam logic [2:0] MPS_4096 = 3'd5;

  localparam int BOUNDARY_4K_BITS = 12;
  localparam int MPS_BEAT_W       = 13;

  // Encodings 6/7 are reserved by PCIe; they saturate to 4096 B.
  function automatic logic [MPS_BEAT_W-1:0] mps_beats(input logic [2:0] mps,
                                                      input int data_bits);
    logic [2:0]            m;
    logic [MPS_BEAT_W-1:0] bytes;
    m     = (mps > MPS_4096) ? MPS_4096 : mps;
    bytes = MPS_BEAT_W'(128) << m;
    return bytes >> data_bits;
  endfunction

endpackage

// File: rtl/al_memwr_sched_if.sv
// MemWr transfer-queue bus: burst request channel plus the engine's
// data-move confirmation stream.
interface al_memwr_sched_if #(
  parameter int LOCAL_ADDR_WIDTH  = 17,
  parameter int REMOTE_ADDR_WIDTH = 32,
  parameter int DATA_BITS         = 4,
  parameter int REQUEST_LEN_BITS  = 6,
  parameter int CH_BITS           = 1
);
  logic                                   m_tcq_valid;
  logic                                   m_tcq_ready;
  logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]  m_tcq_laddr;
  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0] m_tcq_raddr;
  logic [REQUEST_LEN_BITS-1:0]            m_tcq_length;
  logic [CH_BITS-1:0]                     m_tcq_tag;
  logic                                   m_tcq_cvalid;
  logic                                   m_tcq_cready;
  logic [CH_BITS-1:0]                     m_tcq_ctag;

  modport master (
    output m_tcq_valid, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag, m_tcq_cready,
    input  m_tcq_ready, m_tcq_cvalid, m_tcq_ctag
  );

  modport slave (
    input  m_tcq_valid, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag, m_tcq_cready,
    output m_tcq_ready, m_tcq_cvalid, m_tcq_ctag
  );
endinterface

// File: rtl/al_memwr_chunk_calc.sv
// Burst sizing for one channel: min(remaining, MPS, distance to 4 KB, max
// engine length), all terms widened so none is truncated before comparison.
module al_memwr_chunk_calc
  import al_dma_pkg::*;
#(
  parameter int DATA_BITS        = 4,
  parameter int REQUEST_LEN_BITS = 6,
  parameter int DESC_LEN_BITS    = 16
) (
  input  logic [2:0]                              cfg_max_payload,
  input  logic [DESC_LEN_BITS:0]                  remain,
  input  logic [BOUNDARY_4K_BITS-DATA_BITS-1:0]   raddr_lo,
  output logic [REQUEST_LEN_BITS:0]               beats,
  output logic [REQUEST_LEN_BITS-1:0]             length
);
  localparam int BW = BOUNDARY_4K_BITS - DATA_BITS;
  localparam int WA = (DESC_LEN_BITS + 1 > MPS_BEAT_W) ? DESC_LEN_BITS + 1 : MPS_BEAT_W;
  localparam int WB = (REQUEST_LEN_BITS + 1 > BW + 1) ? REQUEST_LEN_BITS + 1 : BW + 1;
  localparam int W  = (WA > WB) ? WA : WB;

  logic [W-1:0] t_rem, t_mps, t_bnd, t_max, m1, m2, mn;

  always_comb begin
    t_rem = W'(remain);
    t_mps = W'(mps_beats(cfg_max_payload, DATA_BITS));
    t_bnd = (W'(1) << BW) - W'(raddr_lo);
    t_max = W'(1) << REQUEST_LEN_BITS;
    m1    = (t_rem < t_mps) ? t_rem : t_mps;
    m2    = (t_bnd < t_max) ? t_bnd : t_max;
    mn    = (m1 < m2) ? m1 : m2;
  end

  // Only meaningful when remain != 0; the caller never grants otherwise.
  assign beats  = (REQUEST_LEN_BITS+1)'(mn);
  assign length = REQUEST_LEN_BITS'(mn - W'(1));

endmodule

// File: rtl/al_memwr_sched.sv
// Multi-channel MemWr burst scheduler: splits descriptors into MPS/4 KB-legal
// bursts, issues them round-robin and tracks per-channel confirmations.
module al_memwr_sched
  import al_dma_pkg::*;
#(
  parameter int LOCAL_ADDR_WIDTH  = 17,
  parameter int REMOTE_ADDR_WIDTH = 32,
  parameter int DATA_BITS         = 4,
  parameter int REQUEST_LEN_BITS  = 6,
  parameter int CH_BITS           = 1,
  parameter int DESC_LEN_BITS     = 16,
  parameter int MAX_OUTSTANDING   = 4,
  localparam int CHANNELS         = 1 << CH_BITS,
  localparam int LBW              = LOCAL_ADDR_WIDTH - DATA_BITS,
  localparam int RBW              = REMOTE_ADDR_WIDTH - DATA_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2:0]                       cfg_max_payload,
  input  logic [CHANNELS-1:0]              s_desc_valid,
  output logic [CHANNELS-1:0]              s_desc_ready,
  input  logic [CHANNELS*LBW-1:0]          s_desc_laddr,
  input  logic [CHANNELS*RBW-1:0]          s_desc_raddr,
  input  logic [CHANNELS*DESC_LEN_BITS-1:0] s_desc_len,
  output logic [CHANNELS-1:0]              desc_done,
  al_memwr_sched_if.master                 tcq,
  output logic                             err_spurious
);
  localparam int BW = BOUNDARY_4K_BITS - DATA_BITS;
  localparam int RW = DESC_LEN_BITS + 1;
  localparam int NW = REQUEST_LEN_BITS + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [CHANNELS-1:0]          active_q, active_d;
  logic [CHANNELS-1:0][LBW-1:0] laddr_q, laddr_d;
  logic [CHANNELS-1:0][RBW-1:0] raddr_q, raddr_d;
  logic [CHANNELS-1:0][RW-1:0]  remain_q, remain_d;
  logic [CHANNELS-1:0][3:0]     outst_q, outst_d;
  logic                         err_q, err_d;

  logic [0:0]                   state_q, state_d;
  logic [CH_BITS-1:0]           rr_q, rr_d;
  logic                         vld_q, vld_d;
  logic [LBW-1:0]               tl_q, tl_d;
  logic [RBW-1:0]               tr_q, tr_d;
  logic [REQUEST_LEN_BITS-1:0]  tlen_q, tlen_d;
  logic [CH_BITS-1:0]           ttag_q, ttag_d;
  logic [NW-1:0]                n_q, n_d;

  logic [CHANNELS-1:0]          elig, done;
  logic                         found;
  logic [CH_BITS-1:0]           grant;
  logic [NW-1:0]                n_calc;
  logic [REQUEST_LEN_BITS-1:0]  len_calc;
  logic                         tcq_hs;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      elig[c] = active_q[c] && (remain_q[c] != '0) && (outst_q[c] < 4'(MAX_OUTSTANDING));
      done[c] = active_q[c] && (remain_q[c] == '0) && (outst_q[c] == '0);
    end
  end

  // Round-robin search starting at rr_q; first eligible channel wins.
  always_comb begin
    logic [CH_BITS-1:0] idx;
    found = 1'b0;
    grant = rr_q;
    idx   = rr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = rr_q + CH_BITS'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  al_memwr_chunk_calc #(
    .DATA_BITS        (DATA_BITS),
    .REQUEST_LEN_BITS (REQUEST_LEN_BITS),
    .DESC_LEN_BITS    (DESC_LEN_BITS)
  ) u_chunk (
    .cfg_max_payload (cfg_max_payload),
    .remain          (remain_q[grant]),
    .raddr_lo        (raddr_q[grant][BW-1:0]),
    .beats           (n_calc),
    .length          (len_calc)
  );

  assign tcq_hs = (state_q == ST_ISSUE) && tcq.m_tcq_ready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    vld_d   = vld_q;
    tl_d    = tl_q;
    tr_d    = tr_q;
    tlen_d  = tlen_q;
    ttag_d  = ttag_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_ISSUE;
          vld_d   = 1'b1;
          tl_d    = laddr_q[grant];
          tr_d    = raddr_q[grant];
          tlen_d  = len_calc;
          ttag_d  = grant;
          n_d     = n_calc;
        end
      end
      default: begin
        if (tcq.m_tcq_ready) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          rr_d    = ttag_q + CH_BITS'(1);
        end
      end
    endcase
  end

  always_comb begin
    logic iss, cfm;
    active_d = active_q;
    laddr_d  = laddr_q;
    raddr_d  = raddr_q;
    remain_d = remain_q;
    outst_d  = outst_q;
    err_d    = err_q;
    iss      = 1'b0;
    cfm      = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      iss = tcq_hs && (ttag_q == CH_BITS'(c));
      cfm = tcq.m_tcq_cvalid && (tcq.m_tcq_ctag == CH_BITS'(c));
      if (done[c]) begin
        active_d[c] = 1'b0;
      end else if (s_desc_valid[c] && !active_q[c]) begin
        active_d[c] = 1'b1;
        laddr_d[c]  = s_desc_laddr[c*LBW +: LBW];
        raddr_d[c]  = s_desc_raddr[c*RBW +: RBW];
        remain_d[c] = RW'(s_desc_len[c*DESC_LEN_BITS +: DESC_LEN_BITS]) + RW'(1);
      end
      if (iss) begin
        laddr_d[c]  = laddr_q[c] + LBW'(n_q);
        raddr_d[c]  = raddr_q[c] + RBW'(n_q);
        remain_d[c] = remain_q[c] - RW'(n_q);
      end
      // A confirmation racing an issue on the same channel cancels out.
      if (iss && !cfm) begin
        outst_d[c] = outst_q[c] + 4'd1;
      end else if (cfm && !iss) begin
        if (outst_q[c] == '0) err_d = 1'b1;
        else                  outst_d[c] = outst_q[c] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      laddr_q  <= '0;
      raddr_q  <= '0;
      remain_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      vld_q    <= 1'b0;
      tl_q     <= '0;
      tr_q     <= '0;
      tlen_q   <= '0;
      ttag_q   <= '0;
      n_q      <= '0;
    end else begin
      active_q <= active_d;
      laddr_q  <= laddr_d;
      raddr_q  <= raddr_d;
      remain_q <= remain_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      state_q  <= state_d;
      rr_q     <= rr_d;
      vld_q    <= vld_d;
      tl_q     <= tl_d;
      tr_q     <= tr_d;
      tlen_q   <= tlen_d;
      ttag_q   <= ttag_d;
      n_q      <= n_d;
    end
  end

  assign s_desc_ready      = ~active_q;
  assign desc_done         = done;
  assign err_spurious      = err_q;
  assign tcq.m_tcq_valid   = vld_q;
  assign tcq.m_tcq_laddr   = tl_q;
  assign tcq.m_tcq_raddr   = tr_q;
  assign tcq.m_tcq_length  = tlen_q;
  assign tcq.m_tcq_tag     = ttag_q;
  assign tcq.m_tcq_cready  = 1'b1;

endmodule

// File: tb/tb_al_memwr_sched.sv
// Directed bench for al_memwr_sched: burst splitting, round-robin order,
// outstanding limit, confirmation accounting and reset behaviour.
module tb_al_memwr_sched;
  localparam int LBW = 13;
  localparam int RBW = 28;

  logic        clk, rst;
  logic [2:0]  cfg;
  logic [1:0]  s_valid, s_ready, done;
  logic [25:0] s_laddr;
  logic [55:0] s_raddr;
  logic [31:0] s_len;
  logic        err;
  int          passed, failed, total;

  al_memwr_sched_if #(.LOCAL_ADDR_WIDTH(17), .REMOTE_ADDR_WIDTH(32), .DATA_BITS(4),
                      .REQUEST_LEN_BITS(6), .CH_BITS(1)) tq ();

  al_memwr_sched dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_max_payload (cfg),
    .s_desc_valid    (s_valid),
    .s_desc_ready    (s_ready),
    .s_desc_laddr    (s_laddr),
    .s_desc_raddr    (s_raddr),
    .s_desc_len      (s_len),
    .desc_done       (done),
    .tcq             (tq),
    .err_spurious    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int c, input logic [LBW-1:0] la, input logic [RBW-1:0] ra,
                          input logic [15:0] ln);
    s_laddr[c*LBW +: LBW] = la;
    s_raddr[c*RBW +: RBW] = ra;
    s_len[c*16 +: 16]     = ln;
  endtask

  // Waits (bounded) for a request, checks it, then lets the handshake edge pass.
  task automatic take_burst(input string nm, input logic [0:0] t, input logic [RBW-1:0] ra,
                            input logic [LBW-1:0] la, input logic [5:0] ln);
    int k;
    k = 0;
    while (!tq.m_tcq_valid && k < 20) begin
      tick();
      k++;
    end
    chk({nm, "_valid"}, 64'(tq.m_tcq_valid), 64'd1);
    chk({nm, "_tag"},   64'(tq.m_tcq_tag),   64'(t));
    chk({nm, "_raddr"}, 64'(tq.m_tcq_raddr), 64'(ra));
    chk({nm, "_laddr"}, 64'(tq.m_tcq_laddr), 64'(la));
    chk({nm, "_len"},   64'(tq.m_tcq_length), 64'(ln));
    tick();
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst = 1'b1; cfg = 3'd0; s_valid = '0; s_laddr = '0; s_raddr = '0; s_len = '0;
    tq.m_tcq_ready = 1'b0; tq.m_tcq_cvalid = 1'b0; tq.m_tcq_ctag = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(tq.m_tcq_valid), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'h3);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_raddr", 64'(tq.m_tcq_raddr), 64'd0);
    chk("rst_laddr", 64'(tq.m_tcq_laddr), 64'd0);
    chk("rst_len",   64'(tq.m_tcq_length), 64'd0);
    chk("rst_cready", 64'(tq.m_tcq_cready), 64'd1);

    // 1 KB at 0x1000 with MPS 256 B: four 16-beat bursts
    cfg = 3'd1;
    set_desc(0, 13'h010, 28'h100, 16'd63);
    s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    chk("t1_rdy_low", 64'(s_ready), 64'h2);
    chk("t1_vld_t1",  64'(tq.m_tcq_valid), 64'd0);
    tick();
    chk("t1_vld_t2",  64'(tq.m_tcq_valid), 64'd1);
    tq.m_tcq_ready = 1'b1;
    take_burst("t1b0", 1'b0, 28'h100, 13'h010, 6'd15);
    take_burst("t1b1", 1'b0, 28'h110, 13'h020, 6'd15);
    take_burst("t1b2", 1'b0, 28'h120, 13'h030, 6'd15);
    take_burst("t1b3", 1'b0, 28'h130, 13'h040, 6'd15);
    tick(); tick(); tick();
    chk("t1_drained", 64'(tq.m_tcq_valid), 64'd0);
    chk("t1_nodone",  64'(done), 64'd0);
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b0;
    tick(); tick(); tick();
    chk("t1_done_early", 64'(done), 64'd0);
    tick();
    tq.m_tcq_cvalid = 1'b0;
    chk("t1_done",     64'(done), 64'h1);
    chk("t1_rdy_held", 64'(s_ready), 64'h2);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_rdy_back",   64'(s_ready), 64'h3);

    // 4 KB split: byte 0x0FC0, 8 beats, MPS 4 KB
    cfg = 3'd5;
    set_desc(0, 13'h000, 28'h0FC, 16'd7);
    s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    take_burst("t2b0", 1'b0, 28'h0FC, 13'h000, 6'd3);
    take_burst("t2b1", 1'b0, 28'h100, 13'h004, 6'd3);
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b0;
    tick(); tick();
    tq.m_tcq_cvalid = 1'b0;
    chk("t2_done", 64'(done), 64'h1);
    tick();

    // Two channels, MPS code 7 (= 4 KB), capped at 64 beats by the engine length
    cfg = 3'd7;
    set_desc(0, 13'h100, 28'h1000, 16'd255);
    s_valid = 2'b01;
    tick();
    set_desc(1, 13'h800, 28'h2000, 16'd255);
    s_valid = 2'b10;
    tick();
    s_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        take_burst($sformatf("t3b%0d", k), 1'b0, 28'h1000 + 28'(64 * (k / 2)),
                   13'h100 + 13'(64 * (k / 2)), 6'd63);
      else
        take_burst($sformatf("t3b%0d", k), 1'b1, 28'h2000 + 28'(64 * (k / 2)),
                   13'h800 + 13'(64 * (k / 2)), 6'd63);
    end
    for (int k = 0; k < 8; k++) begin
      tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'(k % 2);
      tick();
      if (k == 6) chk("t3_done0", 64'(done), 64'h1);
      if (k == 7) chk("t3_done1", 64'(done), 64'h2);
    end
    tq.m_tcq_cvalid = 1'b0;
    tick();

    // Outstanding limit with MPS 128 B (8-beat bursts)
    cfg = 3'd0;
    set_desc(0, 13'h000, 28'h3000, 16'd127);
    s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    for (int k = 0; k < 4; k++)
      take_burst($sformatf("t4b%0d", k), 1'b0, 28'h3000 + 28'(8 * k), 13'(8 * k), 6'd7);
    tick(); tick(); tick(); tick(); tick();
    chk("t4_blocked", 64'(tq.m_tcq_valid), 64'd0);
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b0;
    tick();
    tq.m_tcq_cvalid = 1'b0;
    chk("t4_rel_t1", 64'(tq.m_tcq_valid), 64'd0);
    tick();
    chk("t4_rel_t2",   64'(tq.m_tcq_valid), 64'd1);
    chk("t4_rel_addr", 64'(tq.m_tcq_raddr), 64'h3020);
    // Issue and confirm the same channel in one cycle
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b0;
    tick();
    tq.m_tcq_cvalid = 1'b0;
    take_burst("t4col", 1'b0, 28'h3028, 13'h028, 6'd7);
    tick(); tick(); tick(); tick(); tick();
    chk("t4_col_block", 64'(tq.m_tcq_valid), 64'd0);

    // Spurious confirmation on idle channel 1
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b1;
    tick();
    tq.m_tcq_cvalid = 1'b0;
    chk("t5_err", 64'(err), 64'd1);
    set_desc(1, 13'h040, 28'h4000, 16'd7);
    s_valid = 2'b10;
    tick();
    s_valid = 2'b00;
    take_burst("t5b0", 1'b1, 28'h4000, 13'h040, 6'd7);
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b1;
    tick();
    tq.m_tcq_cvalid = 1'b0;
    chk("t5_done1",   64'(done), 64'h2);
    chk("t5_err_stk", 64'(err), 64'd1);

    // Reset while a request is held with ready low
    tq.m_tcq_ready = 1'b0;
    tq.m_tcq_cvalid = 1'b1; tq.m_tcq_ctag = 1'b0;
    tick();
    tq.m_tcq_cvalid = 1'b0;
    for (int k = 0; k < 5 && !tq.m_tcq_valid; k++) tick();
    chk("t6_vld",   64'(tq.m_tcq_valid), 64'd1);
    chk("t6_addr",  64'(tq.m_tcq_raddr), 64'h3030);
    tick();
    chk("t6_hold",      64'(tq.m_tcq_valid), 64'd1);
    chk("t6_hold_addr", 64'(tq.m_tcq_raddr), 64'h3030);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vld_rst", 64'(tq.m_tcq_valid), 64'd0);
    chk("t6_err_rst", 64'(err), 64'd0);
    tick();
    chk("t6_vld_after", 64'(tq.m_tcq_valid), 64'd0);
    chk("t6_rdy_after", 64'(s_ready), 64'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
